sub16_nibble_sequencer: RTL and testbench

Multi-cycle controller that performs a WIDTH-bit subtraction A − B through one shared external 4-bit subtractor slice. It walks the slice from the low nibble to the high nibble, propagating carry between nibbles. If the result is negative, it runs a second pass through the same slice to form the magnitude (0 − diff). It sits between the calculator front-end (Start/operands) and a single 4-bit subtractor instance, and returns a positive magnitude plus a sign flag.

---
 rtl/sub16_nibble_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_sub16_nibble_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub16_nibble_sequencer.sv
// sub16_nibble_sequencer
//
// Computes a WIDTH-bit subtraction A - B by walking one shared external
// 4-bit subtractor slice from the low nibble to the high nibble. The running
// carry is passed from one nibble to the next. If the final carry-out shows a
// borrow (negative result) and AUTO_NEGATE is set, a second pass through the
// same slice forms 0 - diff. The block then returns a positive magnitude
// together with a sign flag.
//
// Ports:
//   Clk, Reset        rising-edge clock, asynchronous active-high reset
//   Start             request, accepted only while idle or in the done cycle
//   A_in16, B_in16    minuend / subtrahend, latched on an accepted Start
//   Carry_in          initial carry into nibble 0 (1 = plain A - B)
//   Slice_A4/B4       operand nibbles driven to the external slice
//   Slice_Carry_in    carry driven to the external slice
//   Slice_Diff4       slice difference (combinational from the Slice_* outputs)
//   Slice_Carry_out   slice carry-out, 1 = no borrow
//   Busy              high while a subtract or negate pass is running
//   Done              one-cycle pulse when the results are valid
//   Positive_Diff16   magnitude, or the raw difference when AUTO_NEGATE = 0
//   Is_negative       set when the subtract pass ended with a borrow
//
// WIDTH must be a multiple of 4 and at least 4.

module sub16_nibble_sequencer #(
  parameter int WIDTH       = 16,
  parameter bit AUTO_NEGATE = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A_in16,
  input  logic [WIDTH-1:0] B_in16,
  input  logic             Carry_in,
  output logic [3:0]       Slice_A4,
  output logic [3:0]       Slice_B4,
  output logic             Slice_Carry_in,
  input  logic [3:0]       Slice_Diff4,
  input  logic             Slice_Carry_out,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Positive_Diff16,
  output logic             Is_negative
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  opA_q;
  logic [WIDTH-1:0]  opB_q;
  logic [WIDTH-1:0]  work_q;
  logic              carry_q;
  logic              neg_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  result_q;
  logic              isNegative_q;

  logic [IDXW+1:0]   nibbleBase;
  logic [WIDTH-1:0]  work_d;

  // Bit offset of the nibble currently being processed (idx * 4).
  assign nibbleBase = {idx_q, 2'b00};

  // The working result with the current nibble replaced by the slice output.
  // The finishing edge registers this value as the result, so the nibble
  // being written on that same edge is already included.
  always_comb begin
    work_d = work_q;
    work_d[nibbleBase +: 4] = Slice_Diff4;
  end

  // Route the operand nibbles to the shared slice. In the subtract pass the
  // slice sees A and B nibbles. In the negate pass it sees 0 and the working
  // result, which computes 0 - W one nibble at a time. While idle or done,
  // the slice inputs are held at zero.
  always_comb begin
    Slice_A4       = 4'h0;
    Slice_B4       = 4'h0;
    Slice_Carry_in = 1'b0;
    case (state_q)
      SUB: begin
        Slice_A4       = opA_q[nibbleBase +: 4];
        Slice_B4       = opB_q[nibbleBase +: 4];
        Slice_Carry_in = carry_q;
      end
      NEG: begin
        Slice_A4       = 4'h0;
        Slice_B4       = work_q[nibbleBase +: 4];
        Slice_Carry_in = carry_q;
      end
      default: begin
        Slice_A4       = 4'h0;
        Slice_B4       = 4'h0;
        Slice_Carry_in = 1'b0;
      end
    endcase
  end

  // Main sequencer. In the DONE cycle a held Start is accepted exactly like
  // in IDLE, which gives back-to-back operation with no idle gap. Busy and
  // Done are registered together with the state transition so that they
  // line up with the state they describe. Reset clears everything at once,
  // which also aborts any pass that is in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      opA_q        <= '0;
      opB_q        <= '0;
      work_q       <= '0;
      carry_q      <= 1'b0;
      neg_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      isNegative_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (Start) begin
            opA_q   <= A_in16;
            opB_q   <= B_in16;
            carry_q <= Carry_in;
            idx_q   <= '0;
            work_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SUB;
          end else begin
            state_q <= IDLE;
          end
        end

        SUB: begin
          work_q  <= work_d;
          carry_q <= Slice_Carry_out;
          idx_q   <= idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            // A missing carry out of the top nibble means A - B borrowed.
            neg_q <= ~Slice_Carry_out;
            idx_q <= '0;
            if (AUTO_NEGATE && !Slice_Carry_out) begin
              // 0 - W is 0 + ~W + 1, so the negate pass starts with carry 1.
              carry_q <= 1'b1;
              state_q <= NEG;
            end else begin
              state_q      <= DONE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              result_q     <= work_d;
              isNegative_q <= ~Slice_Carry_out;
            end
          end
        end

        NEG: begin
          work_q  <= work_d;
          carry_q <= Slice_Carry_out;
          idx_q   <= idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            idx_q        <= '0;
            state_q      <= DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            result_q     <= work_d;
            isNegative_q <= neg_q;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy            = busy_q;
  assign Done            = done_q;
  assign Positive_Diff16 = result_q;
  assign Is_negative     = isNegative_q;

endmodule

// File: tb/tb_sub16_nibble_sequencer.sv
// Testbench for sub16_nibble_sequencer.
// Two instances share the operand inputs. One has AUTO_NEGATE = 1 and the
// other has AUTO_NEGATE = 0. Each instance is paired with its own behavioural
// 4-bit slice. The useRaw flag selects which instance a request goes to and
// which instance is observed.

module tb_sub16_nibble_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] aIn;
  logic [15:0] bIn;
  logic        carryIn;
  logic        useRaw;

  logic [3:0]  nSliceA, nSliceB, nDiff;
  logic        nSliceCin, nCout, nBusy, nDone, nNeg;
  logic [15:0] nResult;
  logic [4:0]  nSum;

  logic [3:0]  rSliceA, rSliceB, rDiff;
  logic        rSliceCin, rCout, rBusy, rDone, rNeg;
  logic [15:0] rResult;
  logic [4:0]  rSum;

  logic        nStart, rStart;
  logic        curBusy, curDone, curNeg;
  logic [15:0] curResult;
  logic [3:0]  curSliceA, curSliceB;

  int checks = 0;
  int errors = 0;

  logic [3:0] sliceALog [0:63];
  logic [3:0] sliceBLog [0:63];

  always #5 Clk = ~Clk;

  // Behavioural slices: Diff = A + ~B + Cin, with Cout as the carry out.
  assign nSum  = {1'b0, nSliceA} + {1'b0, ~nSliceB} + {4'b0000, nSliceCin};
  assign nDiff = nSum[3:0];
  assign nCout = nSum[4];
  assign rSum  = {1'b0, rSliceA} + {1'b0, ~rSliceB} + {4'b0000, rSliceCin};
  assign rDiff = rSum[3:0];
  assign rCout = rSum[4];

  assign nStart    = Start & ~useRaw;
  assign rStart    = Start & useRaw;
  assign curBusy   = useRaw ? rBusy   : nBusy;
  assign curDone   = useRaw ? rDone   : nDone;
  assign curNeg    = useRaw ? rNeg    : nNeg;
  assign curResult = useRaw ? rResult : nResult;
  assign curSliceA = useRaw ? rSliceA : nSliceA;
  assign curSliceB = useRaw ? rSliceB : nSliceB;

  sub16_nibble_sequencer #(.WIDTH(16), .AUTO_NEGATE(1'b1)) dutNeg (
    .Clk(Clk), .Reset(Reset), .Start(nStart),
    .A_in16(aIn), .B_in16(bIn), .Carry_in(carryIn),
    .Slice_A4(nSliceA), .Slice_B4(nSliceB), .Slice_Carry_in(nSliceCin),
    .Slice_Diff4(nDiff), .Slice_Carry_out(nCout),
    .Busy(nBusy), .Done(nDone), .Positive_Diff16(nResult), .Is_negative(nNeg)
  );

  sub16_nibble_sequencer #(.WIDTH(16), .AUTO_NEGATE(1'b0)) dutRaw (
    .Clk(Clk), .Reset(Reset), .Start(rStart),
    .A_in16(aIn), .B_in16(bIn), .Carry_in(carryIn),
    .Slice_A4(rSliceA), .Slice_B4(rSliceB), .Slice_Carry_in(rSliceCin),
    .Slice_Diff4(rDiff), .Slice_Carry_out(rCout),
    .Busy(rBusy), .Done(rDone), .Positive_Diff16(rResult), .Is_negative(rNeg)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        raw;
    logic [15:0] expMag;
    logic        expNeg;
    int          expLat;
  } vec_t;

  vec_t vecs [12];

  // Compares one value and reports a failure line on a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model built from signed arithmetic on whole operands.
  task automatic refModel(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input bit autoNeg, output logic [15:0] mag,
                          output logic neg, output int lat);
    int diff;
    diff = int'(a) - int'(b) - (cin ? 0 : 1);
    neg  = (diff < 0);
    if (neg && autoNeg) begin
      mag = 16'(-diff);
      lat = 9;
    end else begin
      mag = 16'(diff);
      lat = 5;
    end
  endtask

  // Presents the operands with a one-cycle Start pulse. Returns at the
  // negedge of cycle 1 after the accepting edge.
  task automatic startOp(input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge Clk);
    aIn     = a;
    bIn     = b;
    carryIn = cin;
    Start   = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Waits, with a bounded cycle count, for Done on the selected instance.
  // Logs the slice inputs for every cycle and counts the Busy cycles.
  task automatic waitDone(input int startCycle, output int cycles,
                          output int busyCnt, output bit seen);
    cycles  = startCycle;
    busyCnt = 0;
    seen    = 1'b0;
    forever begin
      if (cycles < 64) begin
        sliceALog[cycles] = curSliceA;
        sliceBLog[cycles] = curSliceB;
      end
      if (curDone) begin
        seen = 1'b1;
        break;
      end
      if (curBusy) busyCnt++;
      if (cycles >= 40) break;
      @(negedge Clk);
      cycles++;
    end
  endtask

  // Runs one full operation and checks its result, sign, latency and busy length.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                               input logic [15:0] expMag, input logic expNeg,
                               input int expLat, input string tag);
    int cycles, busyCnt;
    bit seen;
    startOp(a, b, cin);
    waitDone(1, cycles, busyCnt, seen);
    checkOutput({tag, " done"}, 32'(seen), 32'd1);
    checkOutput({tag, " result"}, 32'(curResult), 32'(expMag));
    checkOutput({tag, " negative"}, 32'(curNeg), 32'(expNeg));
    checkOutput({tag, " latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, " busy cycles"}, 32'(busyCnt), 32'(expLat - 1));
  endtask

  initial begin
    int cycles, busyCnt;
    bit seen;
    bit sawDone;
    logic [15:0] ra, rb, rMag;
    logic rCin, rNegExp;
    int rLat;

    vecs[0]  = '{16'h1234, 16'h0234, 1'b1, 1'b0, 16'h1000, 1'b0, 5};
    vecs[1]  = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 9};
    vecs[2]  = '{16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0FFF, 1'b0, 5};
    vecs[3]  = '{16'hABCD, 16'hABCD, 1'b1, 1'b0, 16'h0000, 1'b0, 5};
    vecs[4]  = '{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b0, 5};
    vecs[5]  = '{16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b1, 9};
    vecs[6]  = '{16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0001, 1'b0, 5};
    vecs[7]  = '{16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0001, 1'b1, 9};
    vecs[8]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 5};
    vecs[9]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b1, 5};
    vecs[10] = '{16'h0003, 16'h0007, 1'b1, 1'b1, 16'hFFFC, 1'b1, 5};
    vecs[11] = '{16'h1234, 16'h0234, 1'b1, 1'b1, 16'h1000, 1'b0, 5};

    Reset   = 1'b1;
    Start   = 1'b0;
    aIn     = '0;
    bIn     = '0;
    carryIn = 1'b0;
    useRaw  = 1'b0;

    // Everything must be cleared while reset is held.
    repeat (2) @(negedge Clk);
    checkOutput("reset busy", 32'(nBusy), 32'd0);
    checkOutput("reset done", 32'(nDone), 32'd0);
    checkOutput("reset result", 32'(nResult), 32'd0);
    checkOutput("reset negative", 32'(nNeg), 32'd0);
    checkOutput("reset slice", 32'({nSliceA, nSliceB, nSliceCin}), 32'd0);
    checkOutput("reset raw result", 32'(rResult), 32'd0);
    Reset = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      useRaw = vecs[i].raw;
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].expMag,
                    vecs[i].expNeg, vecs[i].expLat, $sformatf("vec%0d", i));
      if (i == 0) begin
        checkOutput("vec0 sub slice B", 32'({sliceBLog[1], sliceBLog[2], sliceBLog[3], sliceBLog[4]}),
                    32'h4320);
        checkOutput("vec0 sub slice A", 32'({sliceALog[1], sliceALog[2], sliceALog[3], sliceALog[4]}),
                    32'h4321);
        checkOutput("vec0 done slice", 32'({sliceALog[5], sliceBLog[5]}), 32'h00);
      end
      if (i == 1) begin
        checkOutput("vec1 neg slice B", 32'({sliceBLog[5], sliceBLog[6], sliceBLog[7], sliceBLog[8]}),
                    32'hFFFF);
        checkOutput("vec1 neg slice A", 32'({sliceALog[5], sliceALog[6], sliceALog[7], sliceALog[8]}),
                    32'h0000);
      end
    end

    // Reset in the middle of a subtract pass.
    useRaw = 1'b0;
    startOp(16'h1234, 16'h0234, 1'b1);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checkOutput("midreset busy", 32'(nBusy), 32'd0);
    checkOutput("midreset done", 32'(nDone), 32'd0);
    checkOutput("midreset result", 32'(nResult), 32'd0);
    checkOutput("midreset negative", 32'(nNeg), 32'd0);
    checkOutput("midreset slice", 32'({nSliceA, nSliceB, nSliceCin}), 32'd0);
    @(negedge Clk);
    Reset   = 1'b0;
    sawDone = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (nDone) sawDone = 1'b1;
    end
    checkOutput("midreset no done", 32'(sawDone), 32'd0);
    applyStimulus(16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0, 5, "after reset");

    // Start is pulsed during the subtract pass with different operands.
    startOp(16'h1000, 16'h0001, 1'b1);
    @(negedge Clk);
    aIn   = 16'hFFFF;
    bIn   = 16'h1111;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    waitDone(3, cycles, busyCnt, seen);
    checkOutput("ignored start done", 32'(seen), 32'd1);
    checkOutput("ignored start result", 32'(nResult), 32'h0FFF);
    checkOutput("ignored start latency", 32'(cycles), 32'd5);

    // Back-to-back operations with Start held high.
    @(negedge Clk);
    aIn     = 16'h0003;
    bIn     = 16'h0007;
    carryIn = 1'b1;
    Start   = 1'b1;
    @(negedge Clk);
    aIn = 16'h0009;
    bIn = 16'h0002;
    waitDone(1, cycles, busyCnt, seen);
    checkOutput("b2b first done", 32'(seen), 32'd1);
    checkOutput("b2b first result", 32'(nResult), 32'h0004);
    checkOutput("b2b first negative", 32'(nNeg), 32'd1);
    checkOutput("b2b first latency", 32'(cycles), 32'd9);
    @(negedge Clk);
    Start = 1'b0;
    checkOutput("b2b done one cycle", 32'(nDone), 32'd0);
    checkOutput("b2b restarted busy", 32'(nBusy), 32'd1);
    waitDone(1, cycles, busyCnt, seen);
    checkOutput("b2b second done", 32'(seen), 32'd1);
    checkOutput("b2b second result", 32'(nResult), 32'h0007);
    checkOutput("b2b second negative", 32'(nNeg), 32'd0);
    checkOutput("b2b second latency", 32'(cycles), 32'd5);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      useRaw = ($urandom_range(0, 3) == 0);
      ra     = 16'($urandom);
      rb     = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
      rCin   = ($urandom_range(0, 4) != 0);
      refModel(ra, rb, rCin, !useRaw, rMag, rNegExp, rLat);
      applyStimulus(ra, rb, rCin, rMag, rNegExp, rLat, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
